// File: rtl/aes_encrypt_arbiter.sv
// Two-requester arbiter in front of one iterative AES-128/192/256 encryption core.
// Optional macro AES_ARB_FIXED_PRIO_EN: requester 0 always wins contention (default: round-robin).
module aes_encrypt_arbiter #(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [127:0]   req0_data,
    input  logic [N-1:0]   req0_key,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [127:0]   req1_data,
    input  logic [N-1:0]   req1_key,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [127:0]   rsp_data,
    output logic           busy
);
    // A transfer happens on any rising clk edge where valid && ready are both high;
    // ready never depends on anything registered after acceptance.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]   state;
    logic         owner;
    logic         last_grant;
    logic [127:0] blk_q;
    logic [N-1:0] key_q;
    logic         core_start;
    logic [127:0] core_out;
    logic         core_done;
    logic         grant0;
    logic         grant1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef AES_ARB_FIXED_PRIO_EN
            grant0 = 1'b1;
`else
            grant0 = last_grant;
            grant1 = !last_grant;
`endif
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // Ready is also forced low while reset is held so no handshake can be seen during reset.
    assign req0_ready = !rst && (state == IDLE) && grant0;
    assign req1_ready = !rst && (state == IDLE) && grant1;
    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            blk_q      <= '0;
            key_q      <= '0;
            core_start <= 1'b0;
            rsp_data   <= '0;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    blk_q      <= req1_ready ? req1_data : req0_data;
                    key_q      <= req1_ready ? req1_key  : req0_key;
                    owner      <= req1_ready;
                    last_grant <= req1_ready;
                    core_start <= 1'b1;
                    state      <= RUN;
                end
                RUN: if (core_done) begin
                    rsp_data   <= core_out;
                    core_start <= 1'b0;
                    state      <= RESP;
                end
                RESP: if ((!owner && rsp0_ready) || (owner && rsp1_ready)) begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    Encrypt_Iterative #(.N(N), .Nr(Nr), .Nk(Nk)) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (core_start),
        .in    (blk_q),
        .key   (key_q),
        .out   (core_out),
        .done  (core_done)
    );
endmodule

// Iterative AES encryption core: one round per cycle while start is high, combinational key schedule.
// done is high once all Nr rounds are complete; dropping start clears the round counter.
module Encrypt_Iterative #(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [127:0]   in,
    input  logic [N-1:0]   key,
    output logic [127:0]   out,
    output logic           done
);
    localparam int NW = 4 * (Nr + 1);
    localparam int CW = $clog2(Nr + 2);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] v;
        sq = a;
        v  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            v  = gmul(v, sq);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [128*(Nr+1)-1:0] expand(input logic [N-1:0] k);
        logic [31:0] w [NW];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [128*(Nr+1)-1:0] r;
        rc = 8'h01;
        for (int i = 0; i < Nk; i++) w[i] = k[N-1-32*i -: 32];
        for (int i = Nk; i < NW; i++) begin
            t = w[i-1];
            if (i % Nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (Nk > 6 && i % Nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-Nk] ^ t;
        end
        for (int j = 0; j <= Nr; j++) r[128*j +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        return r;
    endfunction

    // Byte i of the state is bits [127-8i -: 8]; bytes are column-major (row r, column c -> 4c+r).
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) t[4*c+rr] = b[4*((c+rr)%4)+rr];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
            else o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o ^ rk;
    endfunction

    logic [CW-1:0]         cnt;
    logic [127:0]          st;
    logic [128*(Nr+1)-1:0] rk_all;

    assign rk_all = expand(key);
    assign out    = st;
    assign done   = (cnt == CW'(Nr + 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            st  <= '0;
        end else if (!start) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            st  <= in ^ rk_all[127:0];
            cnt <= CW'(1);
        end else if (cnt <= CW'(Nr)) begin
            st  <= aes_round(st, rk_all[128*cnt +: 128], cnt == CW'(Nr));
            cnt <= cnt + 1'b1;
        end else begin
            // start still high after completion: re-arm; the next start=0 cycle parks the counter
            cnt <= '0;
        end
    end
endmodule

// File: tb/tb_aes_encrypt_arbiter.sv
// Directed bench for aes_encrypt_arbiter: table of single requests plus contention,
// backpressure, back-to-back and reset-mid-RUN sequences.
module tb_aes_encrypt_arbiter;
    localparam int N = 128;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic           req0_ready, req1_ready;
    logic [127:0]   req0_data = '0, req1_data = '0;
    logic [N-1:0]   req0_key = '0, req1_key = '0;
    logic           rsp0_valid, rsp1_valid;
    logic           rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [127:0]   rsp_data;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit           sel;
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;
    vec_t vecs[4];
    logic [128:0] exp_q[$];

    aes_encrypt_arbiter #(.N(N), .Nr(10), .Nk(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        rst = 1;
        repeat (2) step();
        rst = 0;
        step();
    endtask

    // driver: present a request and return just after the accepting edge
    task automatic send(input bit sel, input logic [127:0] pt, input logic [N-1:0] k);
        int n;
        n = 0;
        if (sel) begin req1_data = pt; req1_key = k; req1_valid = 1; end
        else begin req0_data = pt; req0_key = k; req0_valid = 1; end
        #1;
        while (!(sel ? req1_ready : req0_ready) && n < 100) begin step(); n++; end
        chk("accept_timeout", (n < 100), 1);
        step();
        if (sel) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic wait_rsp(input bit sel, output int n);
        n = 0;
        do begin step(); n++; end while (!(sel ? rsp1_valid : rsp0_valid) && n < 40);
    endtask

    task automatic finish_rsp(input bit sel);
        if (sel) rsp1_ready = 1; else rsp0_ready = 1;
        step();
        rsp0_ready = 0; rsp1_ready = 0;
        chk("rsp_drop", {rsp1_valid, rsp0_valid}, 0);
        chk("busy_fall", busy, 0);
    endtask

    initial begin
        int n;
        bit exp_w;
        bit seen;
        int acc;
        int last_cyc;
        int guard;
        logic [128:0] e;

        vecs[0] = '{sel: 1'b0, pt: P1, key: K1, ct: C1};
        vecs[1] = '{sel: 1'b1, pt: P2, key: K2, ct: C2};
        vecs[2] = '{sel: 1'b1, pt: '0, key: '0, ct: C0};
        vecs[3] = '{sel: 1'b0, pt: P2, key: K2, ct: C2};

        // reset state, with a request held during reset
        req0_valid = 1;
        step();
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        req0_valid = 0;
        rst = 0;
        step();

        // table-driven single requests
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].sel, vecs[i].pt, vecs[i].key);
            chk("busy_rise", busy, 1);
            wait_rsp(vecs[i].sel, n);
            chk("latency", n, 12);
            chk("ct", rsp_data, vecs[i].ct);
            chk("other_rsp_valid", vecs[i].sel ? rsp0_valid : rsp1_valid, 0);
            finish_rsp(vecs[i].sel);
        end

        // contention after reset: requester 0 first
        do_reset();
        req0_data = P1; req0_key = K1; req1_data = P2; req1_key = K2;
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("cont_ready0", req0_ready, 1);
        chk("cont_ready1", req1_ready, 0);
        step();
        req0_valid = 0;
        #1;
        chk("run_ready1", req1_ready, 0);
        wait_rsp(0, n);
        chk("cont_latency0", n, 12);
        chk("cont_ct0", rsp_data, C1);

        // backpressure with the wrong owner's ready asserted
        rsp1_ready = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_rsp_data", rsp_data, C1);
            chk("bp_req_ready", {req1_ready, req0_ready}, 0);
            chk("bp_rsp1_valid", rsp1_valid, 0);
        end
        rsp1_ready = 0;
        rsp0_ready = 1;
        step();
        rsp0_ready = 0;
        #1;
        chk("post_hs_req1_ready", req1_ready, 1);
        step();
        req1_valid = 0;
        wait_rsp(1, n);
        chk("cont_latency1", n, 12);
        chk("cont_ct1", rsp_data, C2);
        chk("cont_rsp0_quiet", rsp0_valid, 0);
        finish_rsp(1);

        // repeated contention right after requester 0 was served
        send(0, P1, K1);
        wait_rsp(0, n);
        finish_rsp(0);
`ifdef AES_ARB_FIXED_PRIO_EN
        exp_w = 0;
`else
        exp_w = 1;
`endif
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rr_ready1", req1_ready, exp_w);
        chk("rr_ready0", req0_ready, !exp_w);
        step();
        req0_valid = 0; req1_valid = 0;
        wait_rsp(exp_w, n);
        chk("rr_latency", n, 12);
        chk("rr_ct", rsp_data, exp_w ? C2 : C1);
        finish_rsp(exp_w);

        // back-to-back with both requesters always valid and responses always ready
        do_reset();
        req0_data = P1; req0_key = K1; req1_data = P2; req1_key = K2;
        req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
        exp_w = 0; acc = 0; last_cyc = -1; guard = 0;
        #1;
        while (acc < 4 && guard < 150) begin
            if (rsp0_valid || rsp1_valid) begin
                if (exp_q.size() == 0) chk("b2b_spurious_rsp", 1, 0);
                else begin e = exp_q.pop_front(); chk("b2b_rsp", {rsp1_valid, rsp_data}, e); end
            end
            if (req0_ready || req1_ready) begin
                chk("b2b_winner", req1_ready, exp_w);
                if (last_cyc >= 0) chk("b2b_spacing", cyc - last_cyc, 14);
                last_cyc = cyc;
                acc++;
                exp_q.push_back({exp_w, exp_w ? C2 : C1});
`ifndef AES_ARB_FIXED_PRIO_EN
                exp_w = !exp_w;
`endif
            end
            step();
            guard++;
        end
        chk("b2b_count", acc, 4);
        req0_valid = 0; req1_valid = 0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 30) begin
            if (rsp0_valid || rsp1_valid) begin
                e = exp_q.pop_front();
                chk("b2b_last_rsp", {rsp1_valid, rsp_data}, e);
            end
            step();
            guard++;
        end
        chk("b2b_drained", exp_q.size(), 0);
        rsp0_ready = 0; rsp1_ready = 0;
        step();

        // reset in the middle of RUN
        send(0, P1, K1);
        repeat (5) step();
        req1_data = P2; req1_key = K2; req1_valid = 1;
        rst = 1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("mid_rst_req_ready", {req1_ready, req0_ready}, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        step();
        req1_valid = 0;
        rst = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp0_valid || rsp1_valid || busy) seen = 1;
        end
        chk("mid_rst_no_rsp", seen, 0);
        send(0, P1, K1);
        wait_rsp(0, n);
        chk("post_rst_latency", n, 12);
        chk("post_rst_ct", rsp_data, C1);
        finish_rsp(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
